// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared types for the MEM pipeline stage.
//   mem_op_t    : operation code presented by EX (PASS, LOAD, STORE, NOP)
//   mem_state_t : stage FSM state (IDLE accepts ops, BUSY is waiting on the RAM)
//   CNT_W       : width of the latency counter (enough for LAT_MAX-1)
//   lat_is_legal: elaboration-time check of the LAT parameter
// -----------------------------------------------------------------------------
package mem_pkg;

    typedef enum logic [1:0] {
        PASS  = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2,
        NOP   = 2'd3
    } mem_op_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 8;
    localparam int CNT_W   = 4;

    function automatic bit lat_is_legal(input int lat);
        return (lat >= LAT_MIN) && (lat <= LAT_MAX);
    endfunction

endpackage

// File: rtl/mem_ram.sv
// -----------------------------------------------------------------------------
// mem_ram
// Single-port synchronous data RAM, DEPTH words of ARQ bits. Array contents
// are never reset. A read returns the contents before any same-edge write.
// Ports:
//   clk   : rising-edge clock
//   en    : perform an access on this edge
//   we    : write wdata to addr (only when en)
//   addr  : word index
//   wdata : write data
//   rdata : registered read data, updated on every enabled edge
// -----------------------------------------------------------------------------
module mem_ram #(
    parameter int ARQ   = 16,
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic           clk,
    input  logic           en,
    input  logic           we,
    input  logic [AW-1:0]  addr,
    input  logic [ARQ-1:0] wdata,
    output logic [ARQ-1:0] rdata
);

    logic [ARQ-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
// MEM pipeline stage between EX and WB. Non-memory results pass through in one
// cycle; loads and stores take LAT cycles and hold off EX via in_ready.
//
// Handshake: an op transfers at a rising edge when in_valid & in_ready & ~flush.
// in_ready depends only on the FSM state, never on in_valid. Results reach WB
// as a one-cycle out_valid pulse with no back-pressure from WB.
//
// Ports:
//   clk, rst         : clock, asynchronous active-low reset
//   in_valid/in_ready: upstream handshake (stall = ~in_ready)
//   in_op            : PASS / LOAD / STORE / NOP
//   in_alu_result    : ALU result, also the word address for LOAD/STORE
//   in_store_data    : STORE data
//   in_rd            : destination register
//   flush            : synchronous kill of the in-flight op and same-cycle input
//   out_valid        : result pulse to WB
//   out_result       : PASS value, load data, or 0 for STORE
//   out_rd           : destination register of the completed op
//   out_we           : register-file write enable (PASS and LOAD)
//   addr_err         : pulses with out_valid when the address is >= DEPTH
//   dbg_state        : current FSM state
// -----------------------------------------------------------------------------
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int ARQ   = 16,
    parameter int DEPTH = 256,
    parameter int LAT   = 2,
    parameter int RA    = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [1:0]     in_op,
    input  logic [ARQ-1:0] in_alu_result,
    input  logic [ARQ-1:0] in_store_data,
    input  logic [RA-1:0]  in_rd,
    input  logic           flush,
    output logic           out_valid,
    output logic [ARQ-1:0] out_result,
    output logic [RA-1:0]  out_rd,
    output logic           out_we,
    output logic           addr_err,
    output mem_state_t     dbg_state
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // DEPTH widened by one bit so the range test works on the full address.
    localparam logic [ARQ:0] DEPTH_W = DEPTH[ARQ:0];

    if (!lat_is_legal(LAT)) begin : g_bad_lat
        $error("mem_access_stage: LAT=%0d is outside %0d..%0d", LAT, LAT_MIN, LAT_MAX);
    end

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    mem_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fire_q, fire_d;     // captured op executes on the next edge
    logic             capture;

    // Operands captured at acceptance
    mem_op_t          op_q;
    logic [ARQ-1:0]   addr_q;
    logic [ARQ-1:0]   data_q;
    logic [RA-1:0]    rd_q;

    // Output registers
    logic             out_valid_q;
    logic             out_we_q;
    logic             addr_err_q;
    logic [ARQ-1:0]   res_q;
    logic [RA-1:0]    out_rd_q;
    logic             from_ram_q;

    mem_op_t          op_in;
    logic             accept;
    logic             is_mem_in;
    logic             is_mem_q;
    logic             addr_ok;
    logic             fire_now;
    logic             ram_en;
    logic             ram_we;
    logic [ARQ-1:0]   ram_rdata;

    assign op_in     = mem_op_t'(in_op);
    assign in_ready  = (state_q == IDLE);
    assign accept    = in_valid & in_ready & ~flush;
    assign is_mem_in = (op_in == LOAD) || (op_in == STORE);
    assign is_mem_q  = (op_q == LOAD) || (op_q == STORE);
    assign addr_ok   = ({1'b0, addr_q} < DEPTH_W);

    // A flush in the cycle before execution still cancels the op.
    assign fire_now  = fire_q & ~flush;

    // ------------------------------------------------------------------
    // FSM. The counter reaching zero releases in_ready; the RAM access and
    // the result register load happen on the following edge, the same edge
    // a PASS accepted one cycle earlier would execute on.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fire_d  = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    capture = 1'b1;
                    if (is_mem_in && (LAT > 1)) begin
                        state_d = BUSY;
                        cnt_d   = CNT_W'(LAT - 1);
                    end else begin
                        fire_d = (op_in != NOP);
                    end
                end
            end
            BUSY: begin
                if (flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = IDLE;
                        fire_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            fire_q  <= 1'b0;
            op_q    <= NOP;
            addr_q  <= '0;
            data_q  <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fire_q  <= fire_d;
            if (capture) begin
                op_q   <= op_in;
                addr_q <= in_alu_result;
                data_q <= in_store_data;
                rd_q   <= in_rd;
            end
        end
    end

    // ------------------------------------------------------------------
    // Data RAM. Out-of-range accesses never reach the array, which both
    // suppresses the store and avoids reading past the last word.
    // ------------------------------------------------------------------
    assign ram_en = fire_now & is_mem_q & addr_ok;
    assign ram_we = (op_q == STORE);

    mem_ram #(
        .ARQ   (ARQ),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (addr_q[AW-1:0]),
        .wdata (data_q),
        .rdata (ram_rdata)
    );

    // ------------------------------------------------------------------
    // Output registers. Load data comes straight from the RAM's read
    // register, selected by from_ram_q, so it lines up with out_valid.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_we_q    <= 1'b0;
            addr_err_q  <= 1'b0;
            res_q       <= '0;
            out_rd_q    <= '0;
            from_ram_q  <= 1'b0;
        end else begin
            out_valid_q <= fire_now;
            out_we_q    <= fire_now & ((op_q == PASS) || (op_q == LOAD));
            addr_err_q  <= fire_now & is_mem_q & ~addr_ok;
            if (fire_now) begin
                out_rd_q   <= rd_q;
                res_q      <= (op_q == PASS) ? addr_q : '0;
                from_ram_q <= (op_q == LOAD) && addr_ok;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_we     = out_we_q;
    assign addr_err   = addr_err_q;
    assign out_rd     = out_rd_q;
    assign out_result = from_ram_q ? ram_rdata : res_q;
    assign dbg_state  = state_q;

endmodule
